// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: packet-granular round-robin arbiter sharing one TX FIFO
// write port among four byte-stream requesters. A grant is held for a whole
// packet so bytes from different sources never interleave; overlong packets
// and stalled owners are cut off so no requester can hog the link.
module tx_fifo_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_PKT_LEN   = 64,
  parameter int STALL_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] reqData,
  input  logic [3:0]  reqLast,
  output logic [3:0]  reqAck,
  output logic [3:0]  grant,
  output logic        wrEn,
  output logic [7:0]  din,
  input  logic        full,
  output logic        lenErr,
  output logic        stallErr,
  output logic        busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [7:0]       MAX_LEN   = 8'(MAX_PKT_LEN);
  localparam logic [15:0]      STALL_LIM = 16'(STALL_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       grant_q;
  logic [IDX_W-1:0] gidx_q;
  logic [IDX_W-1:0] lastOwner_q;
  logic [7:0]       byteCnt_q;
  logic [15:0]      stallCnt_q;
  logic             lenErr_q;
  logic             stallErr_q;
  logic             busy_q;

  logic             accept;
  logic [IDX_W-1:0] sel_d;
  logic [7:0]       byteCnt_d;
  logic [15:0]      stallCnt_d;

  // Round-robin pick: first set request after 'last', wrapping; scanning
  // downward lets the nearest candidate overwrite farther ones.
  function automatic logic [IDX_W-1:0] pick_next(input logic [3:0] r,
                                                 input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last + IDX_W'(i);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign sel_d      = pick_next(req, lastOwner_q);
  assign byteCnt_d  = byteCnt_q + 8'd1;
  assign stallCnt_d = stallCnt_q + 16'd1;
  // A byte moves only for the owner, only while in a packet, and never into a full FIFO.
  assign accept     = (state_q == XFER) && req[gidx_q] && !full;

  // Write-side strobes follow the owner's handshake combinationally.
  always_comb begin
    reqAck         = 4'b0000;
    reqAck[gidx_q] = accept;
    wrEn           = accept;
    din            = 8'h00;
    if (state_q == XFER) din = reqData[{gidx_q, 3'b000} +: 8];
  end

  // Arbitration FSM with registered grant, error pulses and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 4'b0000;
      gidx_q      <= '0;
      lastOwner_q <= LAST_IDX;
      byteCnt_q   <= 8'd0;
      stallCnt_q  <= 16'd0;
      lenErr_q    <= 1'b0;
      stallErr_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          lenErr_q   <= 1'b0;
          stallErr_q <= 1'b0;
          if (|req) begin
            gidx_q  <= sel_d;
            grant_q <= 4'b0001 << sel_d;
            busy_q  <= 1'b1;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            byteCnt_q  <= byteCnt_d;
            stallCnt_q <= 16'd0;
            if (reqLast[gidx_q]) begin
              grant_q <= 4'b0000;
              state_q <= RELEASE;
            end else if (byteCnt_d == MAX_LEN) begin
              grant_q  <= 4'b0000;
              lenErr_q <= 1'b1;
              state_q  <= RELEASE;
            end
          end else if (!req[gidx_q]) begin
            // Only an idle owner ages; a FULL-blocked write is not a stall.
            if (stallCnt_q == STALL_LIM) begin
              grant_q    <= 4'b0000;
              stallErr_q <= 1'b1;
              state_q    <= RELEASE;
            end else begin
              stallCnt_q <= stallCnt_d;
            end
          end
        end
        RELEASE: begin
          grant_q     <= 4'b0000;
          lastOwner_q <= gidx_q;
          byteCnt_q   <= 8'd0;
          stallCnt_q  <= 16'd0;
          lenErr_q    <= 1'b0;
          stallErr_q  <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          grant_q <= 4'b0000;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign lenErr   = lenErr_q;
  assign stallErr = stallErr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// tb_tx_fifo_arbiter: directed, table-driven bench for tx_fifo_arbiter.
// Each table row is one clock cycle: inputs driven after the falling edge
// and every output checked before the next rising edge.
module tb_tx_fifo_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] reqData;
  logic [3:0]  reqLast;
  logic [3:0]  reqAck;
  logic [3:0]  grant;
  logic        wrEn;
  logic [7:0]  din;
  logic        full;
  logic        lenErr;
  logic        stallErr;
  logic        busy;

  int total = 0;
  int bad   = 0;

  tx_fifo_arbiter #(
    .NUM_REQ      (4),
    .MAX_PKT_LEN  (4),
    .STALL_TIMEOUT(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .reqData (reqData),
    .reqLast (reqLast),
    .reqAck  (reqAck),
    .grant   (grant),
    .wrEn    (wrEn),
    .din     (din),
    .full    (full),
    .lenErr  (lenErr),
    .stallErr(stallErr),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic        full;
    logic [31:0] data;
    logic [3:0]  g;
    logic        wr;
    logic [7:0]  din;
    logic [3:0]  ack;
    logic        len;
    logic        stl;
    logic        bsy;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic [3:0] r, input logic [3:0] l, input logic f,
                   input logic [31:0] d, input logic [3:0] g, input logic wr,
                   input logic [7:0] dn, input logic len, input logic stl,
                   input logic bsy);
    vec_t e;
    e.req = r; e.last = l; e.full = f; e.data = d;
    e.g = g; e.wr = wr; e.din = dn; e.ack = wr ? g : 4'b0000;
    e.len = len; e.stl = stl; e.bsy = bsy;
    tv.push_back(e);
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic wr,
                           input logic [7:0] dn, input logic [3:0] ack,
                           input logic len, input logic stl, input logic bsy);
    chk({tag, ".grant"},    32'(grant),    32'(g));
    chk({tag, ".wrEn"},     32'(wrEn),     32'(wr));
    chk({tag, ".din"},      32'(din),      32'(dn));
    chk({tag, ".reqAck"},   32'(reqAck),   32'(ack));
    chk({tag, ".lenErr"},   32'(lenErr),   32'(len));
    chk({tag, ".stallErr"}, 32'(stallErr), 32'(stl));
    chk({tag, ".busy"},     32'(busy),     32'(bsy));
  endtask

  initial begin
    logic [31:0] rr;
    logic [31:0] t4;
    int          k;

    rst = 1'b1; req = 4'b0; reqData = 32'h0; reqLast = 4'b0; full = 1'b0;

    // Single packet from requester 0 straight out of reset.
    v(4'h1, 4'h0, 1'b0, 32'h41, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    v(4'h1, 4'h0, 1'b0, 32'h41, 4'h1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
    v(4'h1, 4'h0, 1'b0, 32'h42, 4'h1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1);
    v(4'h1, 4'h1, 1'b0, 32'h43, 4'h1, 1'b1, 8'h43, 1'b0, 1'b0, 1'b1);
    v(4'h0, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    v(4'h0, 4'h0, 1'b0, 32'h0,  4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // All four requesting 1-byte packets: owner 0 went last, so 1,2,3,0,1.
    rr = 32'hA3A2A1A0;
    for (int p = 0; p < 5; p++) begin
      k = (p + 1) % 4;
      v(4'hF, 4'hF, 1'b0, rr, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      v(4'hF, 4'hF, 1'b0, rr, 4'(1 << k), 1'b1, 8'(8'hA0 + k), 1'b0, 1'b0, 1'b1);
      v(4'hF, 4'hF, 1'b0, rr, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    v(4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Requester 3 packet with FULL held for 5 cycles after the first byte.
    v(4'h8, 4'h0, 1'b0, 32'h31000000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    v(4'h8, 4'h0, 1'b0, 32'h31000000, 4'h8, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      v(4'h8, 4'h0, 1'b1, 32'h32000000, 4'h8, 1'b0, 8'h32, 1'b0, 1'b0, 1'b1);
    v(4'h8, 4'h0, 1'b0, 32'h32000000, 4'h8, 1'b1, 8'h32, 1'b0, 1'b0, 1'b1);
    v(4'h8, 4'h8, 1'b0, 32'h33000000, 4'h8, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    v(4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    v(4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Requester 2 streams without reqLast: cut after 4 bytes, then 3 is served.
    v(4'hC, 4'h8, 1'b0, 32'hD0510000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      t4 = 32'hD0000000 | (32'(8'h51 + i) << 16);
      v(4'hC, 4'h8, 1'b0, t4, 4'h4, 1'b1, 8'(8'h51 + i), 1'b0, 1'b0, 1'b1);
    end
    v(4'hC, 4'h8, 1'b0, 32'hD0550000, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    v(4'hC, 4'h8, 1'b0, 32'hD0550000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    v(4'hC, 4'h8, 1'b0, 32'hD0550000, 4'h8, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b1);
    v(4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    v(4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset state
    @(negedge clk);
    #2;
    check_all("reset", 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      req = tv[i].req; reqLast = tv[i].last; full = tv[i].full; reqData = tv[i].data;
      #2;
      check_all($sformatf("vec%0d", i), tv[i].g, tv[i].wr, tv[i].din, tv[i].ack,
                tv[i].len, tv[i].stl, tv[i].bsy);
    end

    // Stall: requester 1 sends one byte then goes quiet (timeout 4).
    @(negedge clk);
    req = 4'h2; reqLast = 4'h0; reqData = 32'h00006100;
    #2 check_all("stall.arb", 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 check_all("stall.byte", 4'h2, 1'b1, 8'h61, 4'h2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req = 4'h0;
      #2 check_all($sformatf("stall.wait%0d", i), 4'h2, 1'b0, 8'h61, 4'h0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    #2 check_all("stall.pulse", 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #2 check_all("stall.idle", 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);

    // Reset mid-packet: requester 0 (owner 1 went last) sends 2 of 3 bytes.
    @(negedge clk);
    req = 4'h1; reqLast = 4'h0; reqData = 32'h71;
    #2 check_all("rstmid.arb", 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 check_all("rstmid.b1", 4'h1, 1'b1, 8'h71, 4'h1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reqData = 32'h72;
    #2 check_all("rstmid.b2", 4'h1, 1'b1, 8'h72, 4'h1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reqData = 32'h73; reqLast = 4'h1;
    #1 rst = 1'b1;
    #1 check_all("rstmid.abort", 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; req = 4'h9; reqLast = 4'h9; reqData = 32'h84000081;
    #2 check_all("rstmid.arb2", 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 check_all("rstmid.win0", 4'h1, 1'b1, 8'h81, 4'h1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2 check_all("rstmid.rel", 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
    req = 4'h0;

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
